// File: rtl/vga_frame_checker.sv
// ---------------------------------------------------------------------------
// vga_frame_checker
//
// Passive monitor placed after the VGA output stage. Every clk48 cycle it
// samples hsync/vsync and the 2-bit RGB pixel. For each frame it measures the
// horizontal period, the hsync low width and the number of lines, and it runs a
// CRC-16/CCITT over every pixel sample. The results are published once per
// frame, on the cycle after the vsync falling edge.
//
// Ports
//   clk48        in   pixel clock; the only clock
//   rst_n        in   asynchronous active-low reset
//   hsync        in   active-low horizontal sync
//   vsync        in   active-low vertical sync
//   r_in/g_in/b_in in 2-bit colour channels, sampled every cycle
//   frame_crc    out  CRC of the last complete frame
//   line_count   out  hsync falls in the last complete frame (saturates 1023)
//   h_period     out  most recent line period (saturates 2047)
//   hsync_width  out  most recent hsync low width (saturates 2047)
//   err_h        out  last frame had a bad line period or hsync width
//   err_v        out  last frame line count differed from V_EXPECT
//   frame_valid  out  at least one complete frame measured since reset
//   frame_done   out  one-cycle pulse when the frame outputs update
//   state_dbg    out  FSM state: 0 = SEEK, 1 = RUN
//
// Handshake: none. Inputs are sampled unconditionally every cycle and the
// block never stalls; frame_done is a strobe, not a valid/ready pair.
// ---------------------------------------------------------------------------
module vga_frame_checker #(
  parameter int unsigned H_EXPECT     = 1525,
  parameter int unsigned HSYNC_EXPECT = 183,
  parameter int unsigned V_EXPECT     = 525
) (
  input  logic        clk48,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [1:0]  r_in,
  input  logic [1:0]  g_in,
  input  logic [1:0]  b_in,
  output logic [15:0] frame_crc,
  output logic [9:0]  line_count,
  output logic [10:0] h_period,
  output logic [10:0] hsync_width,
  output logic        err_h,
  output logic        err_v,
  output logic        frame_valid,
  output logic        frame_done,
  output logic        state_dbg
);

  typedef enum logic {SEEK = 1'b0, RUN = 1'b1} state_t;

  state_t      state;
  logic        hs_d;
  logic        vs_d;
  logic [15:0] crc_acc;
  logic [9:0]  line_cnt;
  logic [10:0] per_cnt;
  logic [10:0] wid_cnt;
  logic        line_seen;
  logic        err_h_acc;

  logic        hfall;
  logic        hrise;
  logic        vfall;
  logic [5:0]  sample;
  logic [15:0] crc_next;
  logic [15:0] crc_fresh;
  logic        per_err;
  logic        wid_err;
  logic        line_err;

  // CRC-16/CCITT, MSB first; six serial steps unrolled into one update.
  // bits[5] is shifted in first.
  function automatic logic [15:0] crc6(input logic [15:0] crc_in, input logic [5:0] bits);
    logic [15:0] c;
    c = crc_in;
    for (int i = 5; i >= 0; i--) begin
      if (c[15] ^ bits[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  always_comb begin
    hfall     = hs_d & ~hsync;
    hrise     = ~hs_d & hsync;
    vfall     = vs_d & ~vsync;
    sample    = {r_in, g_in, b_in};
    crc_next  = crc6(crc_acc, sample);
    crc_fresh = crc6(16'hFFFF, sample);
    // Errors are judged on the values being latched this cycle, so a bad
    // measurement that lands on the vfall cycle still reaches err_h.
    per_err   = hfall & line_seen & (per_cnt != 11'(H_EXPECT));
    wid_err   = hrise & (wid_cnt != 11'(HSYNC_EXPECT));
    line_err  = per_err | wid_err;
  end

  assign state_dbg = state;

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEEK;
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
      crc_acc     <= 16'hFFFF;
      line_cnt    <= '0;
      per_cnt     <= '0;
      wid_cnt     <= '0;
      line_seen   <= 1'b0;
      err_h_acc   <= 1'b0;
      frame_crc   <= '0;
      line_count  <= '0;
      h_period    <= '0;
      hsync_width <= '0;
      err_h       <= 1'b0;
      err_v       <= 1'b0;
      frame_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      hs_d       <= hsync;
      vs_d       <= vsync;
      frame_done <= 1'b0;

      // Line period: the count at the fall is the distance from the previous
      // fall, which only means something once a previous fall has been seen.
      if (hfall) begin
        per_cnt   <= 11'd1;
        line_seen <= 1'b1;
        if (line_seen) h_period <= per_cnt;
      end else if (per_cnt != 11'h7FF) begin
        per_cnt <= per_cnt + 11'd1;
      end

      // hsync low width: the fall cycle counts as the first low cycle.
      if (hfall) begin
        wid_cnt <= 11'd1;
      end else if (!hsync && wid_cnt != 11'h7FF) begin
        wid_cnt <= wid_cnt + 11'd1;
      end
      if (hrise) hsync_width <= wid_cnt;

      if (vfall) begin
        // The vfall sample and a coincident hfall belong to the new frame.
        crc_acc   <= crc_fresh;
        line_cnt  <= hfall ? 10'd1 : 10'd0;
        err_h_acc <= 1'b0;
        case (state)
          SEEK: state <= RUN;
          RUN: begin
            frame_crc   <= crc_acc;
            line_count  <= line_cnt;
            err_v       <= (line_cnt != 10'(V_EXPECT));
            err_h       <= err_h_acc | line_err;
            frame_valid <= 1'b1;
            frame_done  <= 1'b1;
          end
          default: state <= SEEK;
        endcase
      end else begin
        crc_acc <= crc_next;
        if (hfall && line_cnt != 10'h3FF) line_cnt <= line_cnt + 10'd1;
        if (line_err) err_h_acc <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_checker.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_checker
//
// Drives reduced-size VGA timing (40 x 10, hsync low 6 cycles, vsync low two
// lines) into vga_frame_checker. A bench-side model follows every driven
// cycle and pushes the expected frame result when a vfall is driven; a
// monitor pops and compares whenever frame_done pulses.
// ---------------------------------------------------------------------------
module tb_vga_frame_checker;

  localparam int H  = 40;
  localparam int HS = 6;
  localparam int V  = 10;

  logic        clk48 = 1'b0;
  logic        rst_n;
  logic        hsync;
  logic        vsync;
  logic [1:0]  r_in;
  logic [1:0]  g_in;
  logic [1:0]  b_in;
  logic [15:0] frame_crc;
  logic [9:0]  line_count;
  logic [10:0] h_period;
  logic [10:0] hsync_width;
  logic        err_h;
  logic        err_v;
  logic        frame_valid;
  logic        frame_done;
  logic        state_dbg;

  vga_frame_checker #(
    .H_EXPECT    (H),
    .HSYNC_EXPECT(HS),
    .V_EXPECT    (V)
  ) dut (
    .clk48      (clk48),
    .rst_n      (rst_n),
    .hsync      (hsync),
    .vsync      (vsync),
    .r_in       (r_in),
    .g_in       (g_in),
    .b_in       (b_in),
    .frame_crc  (frame_crc),
    .line_count (line_count),
    .h_period   (h_period),
    .hsync_width(hsync_width),
    .err_h      (err_h),
    .err_v      (err_v),
    .frame_valid(frame_valid),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk48 = ~clk48;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  // ---------------- counters / scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // {crc[15:0], lines[9:0], err_h, err_v}
  logic [27:0] exp_q[$];
  logic [15:0] obs_crc[$];

  // ---------------- reference model state ----------------
  logic        m_hs_d;
  logic        m_vs_d;
  logic        m_run;
  logic        m_line_seen;
  logic        m_errh;
  logic [15:0] m_crc;
  int          m_lines;
  int          m_cycle;
  int          m_fall_t;

  function automatic logic [15:0] model_crc(input logic [15:0] crc_in, input logic [5:0] d);
    logic [15:0] c;
    c = crc_in;
    for (int i = 5; i >= 0; i--) begin
      c = c ^ {d[i], 15'b0};
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic model_reset();
    m_hs_d      = 1'b1;
    m_vs_d      = 1'b1;
    m_run       = 1'b0;
    m_line_seen = 1'b0;
    m_errh      = 1'b0;
    m_crc       = 16'hFFFF;
    m_lines     = 0;
    m_fall_t    = 0;
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic hs, input logic vs,
                             input logic [1:0] r, input logic [1:0] g, input logic [1:0] b);
    logic hf, hr, vf;
    @(negedge clk48);
    hsync = hs; vsync = vs; r_in = r; g_in = g; b_in = b;
    m_cycle++;
    hf = m_hs_d & ~hs;
    hr = ~m_hs_d & hs;
    vf = m_vs_d & ~vs;
    if (hf) begin
      if (m_line_seen && (m_cycle - m_fall_t) != H) m_errh = 1'b1;
      m_line_seen = 1'b1;
      m_fall_t    = m_cycle;
    end
    if (hr && (m_cycle - m_fall_t) != HS) m_errh = 1'b1;
    if (vf) begin
      if (m_run) exp_q.push_back({m_crc, 10'(m_lines), m_errh, (m_lines != V)});
      m_run   = 1'b1;
      m_crc   = model_crc(16'hFFFF, {r, g, b});
      m_lines = hf ? 1 : 0;
      m_errh  = 1'b0;
    end else begin
      m_crc = model_crc(m_crc, {r, g, b});
      if (hf) m_lines++;
    end
    m_hs_d = hs;
    m_vs_d = vs;
  endtask

  // One video line: hsync low for HS cycles, vsync low on lines 0 and 1.
  task automatic gen_line(input int ln, input int len, input bit rnd, input int flip_col);
    logic [1:0] r, g, b;
    for (int c = 0; c < len; c++) begin
      if (rnd) begin
        r = 2'($urandom_range(0, 3));
        g = 2'($urandom_range(0, 3));
        b = 2'($urandom_range(0, 3));
      end else begin
        r = 2'((ln + c) % 3);
        g = 2'(c % 4);
        b = 2'(ln % 4);
      end
      if (c == flip_col) r = 2'b11;
      drive_cycle((c < HS) ? 1'b0 : 1'b1, (ln < 2) ? 1'b0 : 1'b1, r, g, b);
    end
  endtask

  task automatic gen_frame(input int nlines, input bit rnd, input int flip_ln, input int flip_col);
    for (int l = 0; l < nlines; l++) gen_line(l, H, rnd, (l == flip_ln) ? flip_col : -1);
  endtask

  task automatic release_reset();
    @(negedge clk48);
    hsync = 1'b1; vsync = 1'b1; r_in = 2'b00; g_in = 2'b00; b_in = 2'b00;
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- monitor ----------------
  logic        fd_prev = 1'b0;
  logic [27:0] e;

  always @(negedge clk48) begin
    if (rst_n && frame_done) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL frame_done_unexpected: frame_done=1 with no frame expected");
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (frame_crc !== e[27:12]) begin n_fail++; $display("FAIL frame_crc: got %h expected %h", frame_crc, e[27:12]); end
        n_checks++;
        if (line_count !== e[11:2]) begin n_fail++; $display("FAIL line_count: got %0d expected %0d", line_count, e[11:2]); end
        n_checks++;
        if (err_h !== e[1]) begin n_fail++; $display("FAIL err_h: got %b expected %b", err_h, e[1]); end
        n_checks++;
        if (err_v !== e[0]) begin n_fail++; $display("FAIL err_v: got %b expected %b", err_v, e[0]); end
        n_checks++;
        if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL frame_valid_at_done: got %b expected 1", frame_valid); end
        obs_crc.push_back(frame_crc);
      end
      n_checks++;
      if (fd_prev) begin n_fail++; $display("FAIL frame_done_width: high two cycles, expected one"); end
    end
    fd_prev = frame_done;
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    m_cycle = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk48);
      hsync = 1'($urandom_range(0, 1)); vsync = 1'($urandom_range(0, 1));
      r_in = 2'($urandom_range(0, 3)); g_in = 2'($urandom_range(0, 3)); b_in = 2'($urandom_range(0, 3));
      #1;
      n_checks++;
      if ({frame_crc, line_count, h_period, hsync_width, err_h, err_v, frame_valid, frame_done, state_dbg} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: cycle %0d outputs not all zero (crc=%h lines=%0d hp=%0d hw=%0d fv=%b fd=%b st=%b)",
                 i, frame_crc, line_count, h_period, hsync_width, frame_valid, frame_done, state_dbg);
      end
    end
    release_reset();
  endtask

  task automatic test_nominal();
    gen_frame(V, 1, -1, 0);
    n_checks++;
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL valid_after_first_vfall: got %b expected 0", frame_valid); end
    n_checks++;
    if (state_dbg !== 1'b1) begin n_fail++; $display("FAIL state_after_first_vfall: got %b expected 1", state_dbg); end
    for (int f = 0; f < 2; f++) begin
      gen_frame(V, 1, -1, 0);
      n_checks++;
      if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL valid_nominal: got %b expected 1", frame_valid); end
      n_checks++;
      if (line_count !== 10'(V)) begin n_fail++; $display("FAIL line_count_nominal: got %0d expected %0d", line_count, V); end
      n_checks++;
      if (h_period !== 11'(H)) begin n_fail++; $display("FAIL h_period_nominal: got %0d expected %0d", h_period, H); end
      n_checks++;
      if (hsync_width !== 11'(HS)) begin n_fail++; $display("FAIL hsync_width_nominal: got %0d expected %0d", hsync_width, HS); end
      n_checks++;
      if ({err_h, err_v} !== 2'b00) begin n_fail++; $display("FAIL err_nominal: got err_h=%b err_v=%b expected 0 0", err_h, err_v); end
    end
  endtask

  task automatic test_content();
    gen_frame(V, 0, -1, 0);
    gen_frame(V, 0, 5, 20);
    gen_frame(V, 0, -1, 0);
    n_checks++;
    if (obs_crc.size() < 2) begin
      n_fail++;
      $display("FAIL content_crc_count: got %0d published frames expected at least 2", obs_crc.size());
    end else if (obs_crc[obs_crc.size()-1] === obs_crc[obs_crc.size()-2]) begin
      n_fail++;
      $display("FAIL content_crc_diff: flipped frame crc %h equals clean frame crc, required different",
               obs_crc[obs_crc.size()-1]);
    end
  endtask

  task automatic test_short_line();
    for (int l = 0; l < V; l++) begin
      gen_line(l, (l == 3) ? H - 1 : H, 1, -1);
      if (l == 4) begin
        @(posedge clk48); #1;
        n_checks++;
        if (h_period !== 11'(H - 1)) begin n_fail++; $display("FAIL h_period_short: got %0d expected %0d", h_period, H - 1); end
      end
    end
    gen_line(0, H, 1, -1);
    n_checks++;
    if (err_h !== 1'b1) begin n_fail++; $display("FAIL err_h_short_frame: got %b expected 1", err_h); end
    for (int l = 1; l < V; l++) gen_line(l, H, 1, -1);
    gen_line(0, H, 1, -1);
    n_checks++;
    if (err_h !== 1'b0) begin n_fail++; $display("FAIL err_h_after_short: got %b expected 0", err_h); end
    for (int l = 1; l < V; l++) gen_line(l, H, 1, -1);
  endtask

  task automatic test_line_count();
    gen_frame(V - 1, 1, -1, 0);
    gen_line(0, H, 1, -1);
    n_checks++;
    if (line_count !== 10'(V - 1)) begin n_fail++; $display("FAIL line_count_short_frame: got %0d expected %0d", line_count, V - 1); end
    n_checks++;
    if (err_v !== 1'b1) begin n_fail++; $display("FAIL err_v_short_frame: got %b expected 1", err_v); end
    // Line 0 of this frame has hfall and vfall in the same cycle.
    for (int l = 1; l < V; l++) gen_line(l, H, 1, -1);
    gen_line(0, H, 1, -1);
    n_checks++;
    if (line_count !== 10'(V)) begin n_fail++; $display("FAIL line_count_coincident: got %0d expected %0d", line_count, V); end
    n_checks++;
    if (err_v !== 1'b0) begin n_fail++; $display("FAIL err_v_coincident: got %b expected 0", err_v); end
    for (int l = 1; l < V; l++) gen_line(l, H, 1, -1);
  endtask

  task automatic test_mid_reset();
    for (int l = 0; l < 5; l++) gen_line(l, H, 1, -1);
    gen_line(5, 20, 1, -1);
    @(negedge clk48);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({frame_crc, line_count, h_period, hsync_width, err_h, err_v, frame_valid, frame_done, state_dbg} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_immediate: outputs not zero (crc=%h lines=%0d hp=%0d hw=%0d fv=%b st=%b)",
               frame_crc, line_count, h_period, hsync_width, frame_valid, state_dbg);
    end
    repeat (4) @(negedge clk48);
    release_reset();
    gen_frame(V, 1, -1, 0);
    n_checks++;
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL valid_after_reset_first_vfall: got %b expected 0", frame_valid); end
    gen_frame(V, 1, -1, 0);
    n_checks++;
    if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL valid_after_reset_second_vfall: got %b expected 1", frame_valid); end
  endtask

  task automatic test_drain();
    gen_line(0, H, 1, -1);
    @(posedge clk48); #1;
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d frames never reported, expected 0", exp_q.size()); end
  endtask

  initial begin
    hsync = 1'b1; vsync = 1'b1; r_in = 2'b00; g_in = 2'b00; b_in = 2'b00;
    test_reset();
    test_nominal();
    test_content();
    test_short_line();
    test_line_count();
    test_mid_reset();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_frame_checker.md
# vga_frame_checker

Passive monitor that sits directly downstream of the demo's VGA output stage. It samples the registered hsync/vsync/2-bit-RGB outputs every clk48 cycle. Per frame it measures horizontal period, hsync pulse width and line count, and computes a CRC-16 over every pixel sample. Results are published once per frame for silicon bring-up and for regression benches that compare frames against a golden model.

## Interface
- H_EXPECT, 1525: expected clk48 cycles between hsync falling edges
- HSYNC_EXPECT, 183: expected hsync low width in cycles
- V_EXPECT, 525: expected hsync falling edges per frame
- clk48  in  1  pixel clock; the only clock
- rst_n  in  1  reset, asynchronous, active-low
- hsync  in  1  active-low horizontal sync from the VGA output stage
- vsync  in  1  active-low vertical sync from the VGA output stage
- r_in, g_in, b_in  in  2 each  pixel colour, sampled every cycle
- frame_crc  out  16  CRC of the last complete frame
- line_count  out  10  hsync falls counted in the last complete frame; saturates at 1023
- h_period  out  11  most recent line period; saturates at 2047
- hsync_width  out  11  most recent hsync low width; saturates at 2047
- err_h  out  1  last frame had a line with h_period≠H_EXPECT or hsync_width≠HSYNC_EXPECT
- err_v  out  1  last frame had line_count≠V_EXPECT
- frame_valid  out  1  at least one complete frame measured since reset
- frame_done  out  1  one-cycle pulse when the frame outputs update

## Operation
- Reset: every output is 0. Internal CRC accumulator is 0xFFFF. Line, period and width counters are 0. Sync history flops are 1. State is SEEK.
- Edge detection uses the registered previous value of each sync:
  - hfall = hs_d & ~hsync; hrise = ~hs_d & hsync.
  - vfall is formed the same way from vsync.
- States:
  - SEEK: waits for the first vfall, then moves to RUN. The CRC and line counter restart on that vfall; no frame outputs update.
  - RUN: each vfall publishes the frame and restarts accumulation. The state stays RUN until reset.
- Period counter:
  - On hfall it loads 1; otherwise it increments, saturating at 2047.
  - On hfall, h_period takes the pre-update count. This only happens once a previous hfall has been seen since reset (line_seen flag).
- Width counter:
  - On hfall it loads 1; while hsync stays low it increments, saturating.
  - On hrise, hsync_width takes its value. For a 183-cycle pulse this is 183.
- Per-frame horizontal error: err_h_acc is set when a latched h_period≠H_EXPECT, or when a latched hsync_width≠HSYNC_EXPECT. It is cleared at each vfall.
- CRC:
  - CRC-16/CCITT, polynomial 0x1021, MSB-first, no reflection, no final XOR.
  - Each cycle shifts in 6 bits in this order: r_in[1], r_in[0], g_in[1], g_in[0], b_in[1], b_in[0]. The 6 steps are unrolled into one combinational update.
- On vfall in RUN:
  - frame_crc takes the accumulator value excluding this cycle's sample. The accumulator takes the CRC of 0xFFFF with this cycle's sample, so the vfall sample belongs to the new frame.
  - line_count takes the line counter. The line counter takes 1 if hfall occurs in the same cycle, else 0, so a simultaneous hfall counts toward the new frame.
  - err_v is set to (line counter≠V_EXPECT). err_h takes err_h_acc, including any error latched in this same cycle.
  - frame_valid is set to 1; frame_done pulses.
- Outside vfall, each hfall increments the line counter, saturating at 1023.
- Reset asserted mid-frame: all state returns to the reset values immediately, including a return to SEEK and frame_valid=0.

## Timing
- All outputs are registered.
- frame_* outputs and frame_done change on the clock edge that samples the vfall cycle. frame_done is high for exactly that one following cycle.
- h_period and hsync_width update on the edge that samples the hfall and hrise cycles respectively.
- Latency from an input sample to its effect on the accumulator is one cycle. There is no back-pressure and no input handshake; the block never stalls.
- After reset, frame_valid rises at the second vfall.

## Test plan
- Reset: hold rst_n=0 with toggling inputs → all outputs 0, frame_done never pulses, frame_valid stays 0 through the first vfall.
- Nominal: drive ideal 1525×525 timing with hsync low 183 cycles and vsync low 2 lines, for 3 frames → at the 2nd and 3rd vfall line_count=525, h_period=1525, hsync_width=183, err_h=err_v=0, frame_done is a single cycle, frame_crc matches the software CRC model.
- Content sensitivity: flip one pixel (r_in=2'b11) in frame 3 only → frame_crc differs from frame 2 and matches the model for both frames.
- Short line: shorten one line to 1524 cycles → h_period=1524 after that line, err_h=1 for that frame only, err_h=0 the next frame.
- Line count: send a frame with 524 lines → line_count=524, err_v=1. Then assert hfall and vfall in the same cycle → the next frame's line_count includes that line.
- Mid-frame reset: assert rst_n low at line 200 for 5 cycles → outputs 0 immediately, frame_valid=0 until the second subsequent vfall.
